instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the datapath's instruction field splitter: packs decoded MIPS fields (opcode, rs, rt, rd, shamt, func, imm16, imm26) plus a format select into 32-bit instruction words.
- Encoded words are buffered in a small FIFO and streamed out with a PC tag (base 0x00003000, +4 per word).
- Used by the self-check testbench and the instruction-memory preloader to generate programs for the single-cycle CPU.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- PC_BASE, 32'h00003000, PC tagged on the first word emitted after reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple this cycle
- fmt  input  2  00=R, 01=I, 10=J, 11=NOP
- opcode  input  6  bits [31:26]
- rs  input  5  bits [25:21]
- rt  input  5  bits [20:16]
- rd  input  5  bits [15:11] (R only)
- shamt  input  5  bits [10:6] (R only)
- func  input  6  bits [5:0] (R only)
- imm16  input  16  bits [15:0] (I only)
- imm26  input  26  bits [25:0] (J only)
- out_valid  output  1  out_instr/out_pc valid
- out_ready  input  1  consumer takes the word
- out_instr  output  32  encoded instruction
- out_pc  output  32  address of out_instr
- count  output  log2(DEPTH)+1  FIFO occupancy
- err  output  1  sticky encode error (see Optional Feature)

Behaviour:
- Encoding (combinational, before the FIFO write):
  - R: {opcode,rs,rt,rd,shamt,func}
  - I: {opcode,rs,rt,imm16}
  - J: {opcode,imm26}
  - NOP: 32'h00000000
  - Fields not used by the selected format are ignored.
- Accept: push when in_valid && in_ready. in_ready = (count != DEPTH), combinational from registered state only. No full-bypass: a full FIFO holds in_ready=0 even when out_ready=1.
- Emit: pop when out_valid && out_ready. out_valid = (count != 0). out_instr and out_pc come from registered state (head entry and PC register), so they are stable while out_valid=1 and out_ready=0.
- Latency: a word accepted in cycle N is visible at the output in cycle N+1 at the earliest. No same-cycle pass-through on an empty FIFO.
- Simultaneous push and pop (count not 0, not DEPTH): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is an explicit counter (+1 push, -1 pop, unchanged on both or neither).
- PC register: starts at PC_BASE and adds 4 on every pop. Wraps modulo 2^32 with no flag.
- Reset (any cycle, including mid-stream): count=0, pointers=0, out_valid=0, in_ready=1, out_pc=PC_BASE, out_instr=0, err=0. FIFO contents are discarded. Inputs during the reset cycle are ignored.
- The FIFO storage array needs no reset. out_instr is forced to 0 while count==0.

Optional Feature:
- Macro ENC_CHECK_EN.
- Defined: err sets on any accepted tuple with fmt==00 and opcode!=0, or with fmt==11 and any of opcode/rs/rt/rd/shamt/func non-zero. The word is still encoded and enqueued as normal. err stays set until reset.
- Undefined: err is tied to 0 and no check logic is built.

Test Plan:
- addu: fmt=00, op=0, rs=1, rt=2, rd=3, shamt=0, func=0x21 -> out_instr=0x00221821, out_pc=0x00003000, one cycle after accept.
- I/J sequence: ori (op=0x0D, rs=0, rt=1, imm16=0x1234), then lw (op=0x23, rs=1, rt=2, imm16=4), then j (fmt=10, op=2, imm26=0x0000C00), out_ready=1 throughout -> outputs 0x34011234 @0x3000, 0x8C220004 @0x3004, 0x08000C00 @0x3008.
- Fill/backpressure: out_ready=0, push 5 tuples with DEPTH=4 -> in_ready=0 after the 4th accept, count=4, 5th not accepted. Then out_ready=1 -> 4 words in order, then the 5th is accepted.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved, PC advances by 4 per pop only.
- Reset mid-stream with count=3 -> next cycle count=0, out_valid=0, out_pc=0x3000. First post-reset word is tagged 0x3000.
- ENC_CHECK_EN: R-format with op=0x0D -> err=1 next cycle, word 0x34000000|fields still emitted, err held until reset. Without the macro, err=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-tuple input stream and encoded-word output stream of instr_encoder.
// The encoder connects to the slave modport; a program generator drives the master side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm16, imm26, out_ready,
    input  in_ready, out_valid, out_instr, out_pc
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm16, imm26, out_ready,
    output in_ready, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded MIPS fields into 32-bit words, buffers them in a FIFO and streams them out with a PC tag.
// Define ENC_CHECK_EN to build the sticky err flag for malformed R/NOP tuples; otherwise err is tied low.
module instr_encoder #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_encoder_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc;
  logic [31:0]   enc_word;
  logic          push;
  logic          pop;

  always_comb begin
    enc_word = 32'h0000_0000;
    unique case (bus.fmt)
      2'b00:   enc_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
      2'b01:   enc_word = {bus.opcode, bus.rs, bus.rt, bus.imm16};
      2'b10:   enc_word = {bus.opcode, bus.imm26};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  // Ready/valid depend only on the occupancy counter, so a full FIFO never accepts
  // even while it is being drained in the same cycle.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_instr = (count == '0) ? 32'h0000_0000 : mem[rd_ptr];
  assign bus.out_pc    = pc;

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= PC_BASE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        pc     <= pc + 32'd4;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef ENC_CHECK_EN
  logic bad_tuple;

  // R words must carry opcode 0; a NOP must carry no register/function fields at all.
  always_comb begin
    bad_tuple = 1'b0;
    if (bus.fmt == 2'b00 && bus.opcode != 6'h00) begin
      bad_tuple = 1'b1;
    end else if (bus.fmt == 2'b11 &&
                 {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func} != 32'h0) begin
      bad_tuple = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (push && bad_tuple) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a scoreboard queue of expected words and a PC model
// are checked against the DUT once per cycle, at the falling edge.
module tb_instr_encoder;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_BASE = 32'h0000_3000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count;
  logic       err;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH), .PC_BASE(PC_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_pc;
  logic [31:0] cur_exp;
  logic        cur_bad;
  logic        exp_err;
  logic        last_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic v, input logic [1:0] f, input logic [5:0] op,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] w);
    bus.in_valid = v;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rs       = s;
    bus.rt       = t;
    bus.rd       = d;
    bus.shamt    = sh;
    bus.func     = fn;
    bus.imm16    = i16;
    bus.imm26    = i26;
    cur_exp      = w;
`ifdef ENC_CHECK_EN
    cur_bad = (f == 2'b00 && op != 6'h00) ||
              (f == 2'b11 && (op != 6'h00 || s != 5'd0 || t != 5'd0 || d != 5'd0 ||
                              sh != 5'd0 || fn != 6'h00));
`else
    cur_bad = 1'b0;
`endif
  endtask

  task automatic idle();
    setin(1'b0, 2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0, 32'h0);
  endtask

  // Check all outputs against the model, then book this cycle's handshakes and advance.
  task automatic cycle();
    logic fire;
    logic pop;
    chk("count",     32'(count),         32'(exp_q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() != DEPTH));
    chk("err",       32'(err),           32'(exp_err));
    chk("out_pc",    bus.out_pc,         exp_pc);
    chk("out_instr", bus.out_instr,      (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    fire = bus.in_valid && (exp_q.size() != DEPTH);
    pop  = (exp_q.size() != 0) && bus.out_ready;
    if (pop) begin
      void'(exp_q.pop_front());
      exp_pc = exp_pc + 32'd4;
    end
    if (fire) begin
      exp_q.push_back(cur_exp);
      if (cur_bad) exp_err = 1'b1;
    end
    last_fire = fire;
    @(negedge clk);
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last_fire) break;
    end
    chk("accept_timeout", 32'(last_fire), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_pc  = PC_BASE;
    exp_err = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    idle();
    exp_pc  = PC_BASE;
    exp_err = 1'b0;
    last_fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(1);

    // addu
    bus.out_ready = 1'b1;
    setin(1'b1, 2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FFFFFF, 32'h0022_1821);
    wait_accept();
    idle();
    run(2);

    // ori, lw, j back to back from a fresh PC
    do_reset();
    setin(1'b1, 2'b01, 6'h0D, 5'd0, 5'd1, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h0, 32'h3401_1234);
    wait_accept();
    setin(1'b1, 2'b01, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h8C22_0004);
    wait_accept();
    setin(1'b1, 2'b10, 6'h02, 5'd7, 5'd7, 5'd0, 5'd0, 6'h00, 16'hAAAA, 26'h0000C00, 32'h0800_0C00);
    wait_accept();
    idle();
    run(3);

    // fill with backpressure, 5th tuple waits for space
    bus.out_ready = 1'b0;
    setin(1'b1, 2'b01, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h00, 16'h0001, 26'h0, 32'h2008_0001);
    wait_accept();
    setin(1'b1, 2'b00, 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hFFFF, 26'h0, 32'h0109_5020);
    wait_accept();
    setin(1'b1, 2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'hBEEF, 26'h1555555, 32'h0);
    wait_accept();
    setin(1'b1, 2'b10, 6'h03, 5'd31, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFF);
    wait_accept();
    setin(1'b1, 2'b00, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00, 16'h0000, 26'h0, 32'h0002_1900);
    run(3);
    chk("full_count", 32'(count), 32'd4);
    bus.out_ready = 1'b1;
    wait_accept();
    idle();
    run(6);

    // simultaneous push/pop at count=2
    bus.out_ready = 1'b0;
    setin(1'b1, 2'b01, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 32'h3401_1234);
    wait_accept();
    setin(1'b1, 2'b01, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h8C22_0004);
    wait_accept();
    bus.out_ready = 1'b1;
    setin(1'b1, 2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000C00, 32'h0800_0C00);
    wait_accept();
    setin(1'b1, 2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0000, 26'h0, 32'h0022_1821);
    wait_accept();
    setin(1'b1, 2'b00, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00, 16'h0000, 26'h0, 32'h0002_1900);
    wait_accept();
    chk("sim_count", 32'(count), 32'd2);
    idle();
    run(3);

    // reset mid-stream at count=3; tuple held valid through reset is taken afterwards
    bus.out_ready = 1'b0;
    setin(1'b1, 2'b01, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0001, 26'h0, 32'h2008_0001);
    wait_accept();
    wait_accept();
    wait_accept();
    chk("pre_reset_count", 32'(count), 32'd3);
    setin(1'b1, 2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0000, 26'h0, 32'h0022_1821);
    do_reset();
    chk("post_reset_pc", bus.out_pc, 32'h0000_3000);
    bus.out_ready = 1'b1;
    wait_accept();
    idle();
    run(2);

    // malformed R tuple and NOP with a stray field: still encoded, err sticky when checking is built
    setin(1'b1, 2'b00, 6'h0D, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0000, 26'h0, 32'h3422_1821);
    wait_accept();
    setin(1'b1, 2'b11, 6'h00, 5'd0, 5'd0, 5'd5, 5'd0, 6'h00, 16'h0000, 26'h0, 32'h0);
    wait_accept();
    idle();
    run(4);
    do_reset();
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
